conv_requant: RTL and testbench
===============================

# conv_requant

Requantization stage between the convolution accumulator array and the output-image writer. Takes one signed accumulator result per cycle, adds a per-frame bias, applies ReLU or absolute value, then rounds, shifts and saturates to an unsigned WI-bit pixel. Emits a valid-qualified pixel stream with frame-position markers and a per-frame saturation count. No backpressure: the downstream writer always accepts.

## Interface
- ACC_W, 20, accumulator width (signed two's complement)
- WI, 8, output pixel width (unsigned)
- SH_W, 4, shift-amount width (shift range 0..2^SH_W-1)
- WIDTH, 128, pixels per line
- HEIGHT, 128, lines per frame
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- acc_in  in  ACC_W  signed accumulator sample
- acc_vld  in  1  acc_in valid this cycle
- bias  in  ACC_W  signed bias (sampled at frame start)
- shift  in  SH_W  right-shift amount (sampled at frame start)
- relu_en  in  1  1 = ReLU, 0 = absolute value (sampled at frame start)
- dout  out  WI  output pixel
- vld  out  1  dout valid
- sof  out  1  high with first pixel of a frame
- eof  out  1  high with last pixel (index WIDTH*HEIGHT-1)
- sat_count  out  clog2(WIDTH*HEIGHT)+1  saturated-pixel count of last completed frame

## Operation
- Input counter in_cnt (0..FRAME-1, FRAME=WIDTH*HEIGHT) advances on each acc_vld; wraps to 0 after FRAME-1.
- Config capture: when acc_vld && in_cnt==0, bias/shift/relu_en are registered into cfg_*; cfg_* used for that whole frame. Changes to inputs mid-frame have no effect until the next frame.
- S1: sum = sext(acc_in) + sext(cfg_bias), ACC_W+1 bits, no overflow possible.
- S2: mag = ReLU ? (sum<0 ? 0 : sum) : |sum|, ACC_W+2 bits unsigned (|most-negative| fits). rnd = (cfg_shift==0) ? mag : (mag + 2^(cfg_shift-1)) >> cfg_shift (round half up, logical shift).
- S3: if rnd > 2^WI-1 then dout = 2^WI-1 and sat flag set, else dout = rnd[WI-1:0].
- Config for a sample travels with it through the pipeline (frame boundary back-to-back with new config must not mix configs).
- Output counter out_cnt counts vld pixels; sof when out_cnt==0, eof when out_cnt==FRAME-1, then wraps.
- Saturation counter sat_acc increments per saturated output pixel; on eof, sat_count <= sat_acc (+1 if the eof pixel saturates) and sat_acc <= 0.

## Timing
- Latency: 3 cycles acc_in/acc_vld -> dout/vld. Throughput 1 pixel/cycle; gaps in acc_vld propagate as vld=0 gaps unchanged.
- Reset values: dout=0, vld=0, sof=0, eof=0, sat_count=0; in_cnt=out_cnt=sat_acc=0; pipeline valids 0; cfg_bias=0, cfg_shift=0, cfg_relu=1.
- Reset mid-frame: all in-flight samples discarded, vld drops in the reset cycle (async); first acc_vld after release is treated as pixel 0 and recaptures config.
- dout/sof/eof hold last value when vld=0; consumers qualify with vld only. sof/eof are one-cycle, vld-qualified.
- WIDTH*HEIGHT==1: sof and eof high on the same pixel.

## Test plan
- ACC_W=20, WI=8, shift=2, bias=0, relu_en=1; acc_in 99, 6, 5, -50 back-to-back -> dout 25, 2, 1, 0 at cycles 3..6, vld high 4 cycles.
- relu_en=0, shift=2; acc_in -50, -1 -> dout 13, 0; bias=24, acc_in 1000 -> 255 with saturation counted.
- WIDTH=4, HEIGHT=2, 2 frames of 8 pixels with idle gaps; frame1 has 3 saturating pixels, frame2 none -> sof on pixel 0, eof on pixel 7 each frame; sat_count = 3 after frame1 eof, 0 after frame2 eof.
- Change shift from 2 to 0 at in_cnt=3 of frame1 -> frame1 stays shift=2; frame2 (back-to-back, no gap) uses shift=0, acc_in 200 -> dout 200.
- Assert rst at pixel 5 of frame, release, resume -> vld low immediately, next accepted pixel carries sof, outputs at reset values during rst.
- acc_in = -2^19, bias = -2^19, relu_en=0, shift=0 -> no wrap, dout=255, saturated.

Source files
------------

// File: rtl/conv_requant.sv
// conv_requant: bias, ReLU/abs, round-shift and saturate accumulator samples into pixels
module conv_requant #(
  parameter int ACC_W  = 20,
  parameter int WI     = 8,
  parameter int SH_W   = 4,
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  localparam int FRAME = WIDTH * HEIGHT,
  localparam int CW    = $clog2(FRAME) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             acc_vld,
  input  logic [ACC_W-1:0] bias,
  input  logic [SH_W-1:0]  shift,
  input  logic             relu_en,
  output logic [WI-1:0]    dout,
  output logic             vld,
  output logic             sof,
  output logic             eof,
  output logic [CW-1:0]    sat_count
);
  logic [CW-1:0]      in_cnt, out_cnt, sat_acc;
  logic [ACC_W-1:0]   cfg_bias, cur_bias;
  logic [SH_W-1:0]    cfg_shift, cur_shift, s1_shift;
  logic               cfg_relu, cur_relu, s1_relu, s1_vld, s2_vld;
  logic [ACC_W:0]     sum, s1_sum;
  logic [ACC_W+1:0]   sx, mag, half, rnd, s2_rnd;
  logic               first, last, sat;

  assign first     = in_cnt == '0;
  assign cur_bias  = first ? bias : cfg_bias;
  assign cur_shift = first ? shift : cfg_shift;
  assign cur_relu  = first ? relu_en : cfg_relu;
  assign sum       = {acc_in[ACC_W-1], acc_in} + {cur_bias[ACC_W-1], cur_bias};
  assign last      = out_cnt == CW'(FRAME - 1);
  assign sat       = |s2_rnd[ACC_W+1:WI];

  // stage 2 combinational: rectify / magnitude, then round half up and shift
  always_comb begin
    sx   = {s1_sum[ACC_W], s1_sum};
    mag  = s1_sum[ACC_W] ? (s1_relu ? '0 : -sx) : sx;
    half = (s1_shift == '0) ? '0 : ((ACC_W+2)'(1) << (s1_shift - SH_W'(1)));
    rnd  = (mag + half) >> s1_shift;
  end

  // input side: frame position, per-frame config capture, stage 1 sum with its config
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt    <= '0;
      cfg_bias  <= '0;
      cfg_shift <= '0;
      cfg_relu  <= 1'b1;
      s1_vld    <= 1'b0;
      s1_sum    <= '0;
      s1_shift  <= '0;
      s1_relu   <= 1'b1;
    end else begin
      s1_vld <= acc_vld;
      if (acc_vld) begin
        in_cnt   <= (in_cnt == CW'(FRAME - 1)) ? '0 : in_cnt + CW'(1);
        s1_sum   <= sum;
        s1_shift <= cur_shift;
        s1_relu  <= cur_relu;
        if (first) begin
          cfg_bias  <= bias;
          cfg_shift <= shift;
          cfg_relu  <= relu_en;
        end
      end
    end
  end

  // stage 2 register: rounded, shifted magnitude
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_rnd <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) s2_rnd <= rnd;
    end
  end

  // stage 3: saturate, frame markers and per-frame saturation count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= '0;
      vld       <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      sat_count <= '0;
      out_cnt   <= '0;
      sat_acc   <= '0;
    end else begin
      vld <= s2_vld;
      if (s2_vld) begin
        dout    <= sat ? '1 : s2_rnd[WI-1:0];
        sof     <= out_cnt == '0;
        eof     <= last;
        out_cnt <= last ? '0 : out_cnt + CW'(1);
        sat_acc <= last ? '0 : sat_acc + CW'(sat);
        if (last) sat_count <= sat_acc + CW'(sat);
      end
    end
  end
endmodule

// File: tb/tb_conv_requant.sv
// tb_conv_requant: scoreboard bench for conv_requant on a 4x2 frame
module tb_conv_requant;
  localparam int ACC_W = 20, WI = 8, SH_W = 4, W = 4, H = 2, FRAME = W * H, CW = $clog2(FRAME) + 1;
  logic clk = 0, rst = 1, acc_vld = 0, relu_en = 1;
  logic [ACC_W-1:0] acc_in = '0, bias = '0;
  logic [SH_W-1:0] shift = '0;
  logic [WI-1:0] dout;
  logic vld, sof, eof;
  logic [CW-1:0] sat_count;

  conv_requant #(.ACC_W(ACC_W), .WI(WI), .SH_W(SH_W), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .acc_in(acc_in), .acc_vld(acc_vld), .bias(bias), .shift(shift),
    .relu_en(relu_en), .dout(dout), .vld(vld), .sof(sof), .eof(eof), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {int d; int sat; bit sof; bit eof; int t;} exp_t;
  exp_t q[$];
  int cyc = 0, n_cmp = 0, n_err = 0;
  int m_in = 0, m_sat = 0, c_bias = 0, c_sh = 0;
  bit c_relu = 1;

  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic send(int a, int b, int sh, bit r);
    longint s, m, rv;
    exp_t e;
    acc_in = a[ACC_W-1:0];
    bias = b[ACC_W-1:0];
    shift = sh[SH_W-1:0];
    relu_en = r;
    acc_vld = 1;
    if (m_in == 0) begin
      c_bias = b;
      c_sh = sh;
      c_relu = r;
    end
    s = longint'(a) + longint'(c_bias);
    m = (s < 0) ? (c_relu ? 0 : -s) : s;
    rv = (c_sh == 0) ? m : (m + (longint'(1) << (c_sh - 1))) >> c_sh;
    e.sat = (rv > 255) ? 1 : 0;
    e.d = e.sat ? 255 : int'(rv);
    e.sof = m_in == 0;
    e.eof = m_in == FRAME - 1;
    e.t = cyc;
    q.push_back(e);
    m_in = (m_in == FRAME - 1) ? 0 : m_in + 1;
    @(negedge clk);
    acc_vld = 0;
  endtask

  task automatic idle(int n);
    acc_vld = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_sof"}, sof, 0);
    chk({tag, "_eof"}, eof, 0);
    chk({tag, "_satcnt"}, sat_count, 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) m_sat = 0;
    else if (vld) begin
      if (q.size() == 0) chk("extra_vld", 1, 0);
      else begin
        e = q.pop_front();
        chk("dout", dout, e.d);
        chk("sof", sof, e.sof);
        chk("eof", eof, e.eof);
        chk("latency", cyc - e.t, 3);
        if (e.eof) begin
          chk("sat_count", sat_count, m_sat + e.sat);
          m_sat = 0;
        end else m_sat += e.sat;
      end
    end else if (q.size() > 0 && cyc - q[0].t >= 3) begin
      chk("missing_vld", 0, 1);
      void'(q.pop_front());
    end
  end

  initial begin
    int a, b;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst = 0;
    idle(2);
    // frame 1: shift 2 ReLU; shift/bias inputs change from pixel 3 on and must be ignored
    send(99, 0, 2, 1); send(6, 0, 2, 1); send(5, 0, 2, 1);
    send(-50, 100, 0, 1);
    idle(2);
    send(2000, 100, 0, 1); send(4000, 100, 0, 1); send(-9, 100, 0, 1);
    idle(1);
    send(5000, 0, 0, 1);
    // frame 2 back-to-back: shift 0, nothing saturates
    send(200, 0, 0, 1); send(100, 0, 0, 1); send(0, 0, 0, 1); send(255, 0, 0, 1);
    send(7, 0, 0, 1); send(-5, 0, 0, 1); send(30, 0, 0, 1); send(1, 0, 0, 1);
    // frame 3: absolute value, shift 2, reset after pixel index 4
    send(-50, 0, 2, 0); send(-1, 0, 2, 0); send(10, 0, 2, 0); send(3, 0, 2, 0); send(-2, 0, 2, 0);
    #2 rst = 1;
    #1 chk_reset_outs("rst_async");
    q.delete();
    m_in = 0;
    @(negedge clk);
    chk_reset_outs("rst_hold");
    rst = 0;
    idle(1);
    // frame 4: bias 24, abs, shift 0 with saturation boundaries
    send(1000, 24, 0, 0); send(5, 24, 0, 0); send(-300, 24, 0, 0); send(-24, 24, 0, 0);
    send(-279, 24, 0, 0); send(-280, 24, 0, 0); send(231, 24, 0, 0); send(100, 24, 0, 0);
    idle(1);
    // frame 5: most-negative acc and bias must not wrap
    send(-524288, -524288, 0, 0); send(524287, -524288, 0, 0); send(524032, -524288, 0, 0);
    send(524033, -524288, 0, 0); send(0, -524288, 0, 0); send(524287, -524288, 0, 0);
    send(-524288, -524288, 0, 0); send(524287, -524288, 0, 0);
    // frames 6-8: random config and data with random gaps
    for (int f = 0; f < 3; f++) begin
      b = int'($urandom_range(0, 1048575)) - 524288;
      for (int p = 0; p < FRAME; p++) begin
        a = int'($urandom_range(0, 1048575)) - 524288;
        send(a, b, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    repeat (20) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
